// File: rtl/alu_issue_stage.sv
// ============================================================================
// Module  : alu_issue_stage
// Brief   : RV32I decode/issue stage producing ALU_Control and operands for
//           the execute-stage ALU behind a valid/ready handshake.
//           Define ALU_ISSUE_SKID_EN to add a 2-entry skid buffer with a
//           registered in_ready.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_issue_stage #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [5:0]            ALU_Control,
  output logic [DATA_WIDTH-1:0] operand_A,
  output logic [DATA_WIDTH-1:0] operand_B,
  output logic [4:0]            rd,
  output logic                  illegal
);

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [5:0] c_CTRL_LINK  = 6'b011111;

  typedef struct packed {
    logic [5:0]            ctrl;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [4:0]            rd;
    logic                  illegal;
  } beat_t;

  logic [6:0]            w_opcode;
  logic [2:0]            w_f3;
  logic                  w_f7b;
  logic [DATA_WIDTH-1:0] w_imm_i;
  logic [DATA_WIDTH-1:0] w_imm_s;
  logic [DATA_WIDTH-1:0] w_imm_u;
  logic [DATA_WIDTH-1:0] w_pc_plus4;
  beat_t                 w_dec;
  beat_t                 r_out;
  logic                  r_out_valid;
  logic                  w_in_fire;

  assign w_opcode   = instruction[6:0];
  assign w_f3       = instruction[14:12];
  assign w_f7b      = instruction[30];
  assign w_imm_i    = DATA_WIDTH'($signed(instruction[31:20]));
  assign w_imm_s    = DATA_WIDTH'($signed({instruction[31:25], instruction[11:7]}));
  assign w_imm_u    = DATA_WIDTH'($signed({instruction[31:12], 12'b0}));
  assign w_pc_plus4 = pc + DATA_WIDTH'(4);

  always_comb begin
    w_dec    = '0;
    w_dec.rd = instruction[11:7];
    case (w_opcode)
      c_OPC_OP: begin
        w_dec.ctrl = {2'b00, w_f7b & ((w_f3 == 3'b000) | (w_f3 == 3'b101)), w_f3};
        w_dec.op_a = rs1_data;
        w_dec.op_b = rs2_data;
      end
      c_OPC_OPIMM: begin
        // instruction[30] is immediate data for ADDI, so only SRAI honours it
        w_dec.ctrl = {2'b00, w_f7b & (w_f3 == 3'b101), w_f3};
        w_dec.op_a = rs1_data;
        w_dec.op_b = w_imm_i;
      end
      c_OPC_LOAD: begin
        w_dec.op_a = rs1_data;
        w_dec.op_b = w_imm_i;
      end
      c_OPC_STORE: begin
        w_dec.op_a = rs1_data;
        w_dec.op_b = w_imm_s;
      end
      c_OPC_BRANCH: begin
        if ((w_f3 == 3'b010) || (w_f3 == 3'b011)) begin
          w_dec.illegal = 1'b1;
        end else begin
          w_dec.ctrl = {3'b010, w_f3};
          w_dec.op_a = rs1_data;
          w_dec.op_b = rs2_data;
        end
      end
      c_OPC_JAL, c_OPC_JALR: begin
        w_dec.ctrl = c_CTRL_LINK;
        w_dec.op_a = w_pc_plus4;
      end
      c_OPC_LUI: begin
        w_dec.op_b = w_imm_u;
      end
      c_OPC_AUIPC: begin
        w_dec.op_a = pc;
        w_dec.op_b = w_imm_u;
      end
      default: begin
        w_dec.illegal = 1'b1;
      end
    endcase
  end

  assign w_in_fire = in_valid & in_ready;

`ifdef ALU_ISSUE_SKID_EN
  beat_t r_skid;
  logic  r_skid_valid;

  // in_ready depends only on state, never on out_ready
  assign in_ready = reset & ~r_skid_valid;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || out_ready) begin
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else begin
        r_out_valid <= w_in_fire;
        if (w_in_fire) begin
          r_out <= w_dec;
        end
      end
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = reset & (~r_out_valid | out_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (!r_out_valid || out_ready) begin
      r_out_valid <= w_in_fire;
      if (w_in_fire) begin
        r_out <= w_dec;
      end
    end
  end
`endif

  assign out_valid   = r_out_valid;
  assign ALU_Control = r_out.ctrl;
  assign operand_A   = r_out.op_a;
  assign operand_B   = r_out.op_b;
  assign rd          = r_out.rd;
  assign illegal     = r_out.illegal;

endmodule

`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
// ============================================================================
// Module  : tb_alu_issue_stage
// Brief   : Directed scoreboard bench for alu_issue_stage (both builds).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_issue_stage;

  typedef struct packed {
    logic [5:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instruction = '0;
  logic [31:0] pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  ALU_Control;
  logic [31:0] operand_A;
  logic [31:0] operand_B;
  logic [4:0]  rd;
  logic        illegal;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  alu_issue_stage #(.DATA_WIDTH(32)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALU_Control(ALU_Control), .operand_A(operand_A), .operand_B(operand_B),
    .rd(rd), .illegal(illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decoder written straight from the opcode/funct tables
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [31:0] ii, is, iu;
    ii = {{20{ins[31]}}, ins[31:20]};
    is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    iu = {ins[31:12], 12'h000};
    e = '0;
    e.rd = ins[11:7];
    case (ins[6:0])
      7'h33, 7'h13: begin
        e.a = r1;
        e.b = (ins[6:0] == 7'h33) ? r2 : ii;
        case (ins[14:12])
          3'd0: e.ctrl = (ins[6:0] == 7'h33 && ins[30]) ? 6'b001000 : 6'b000000;
          3'd1: e.ctrl = 6'b000001;
          3'd2: e.ctrl = 6'b000010;
          3'd3: e.ctrl = 6'b000011;
          3'd4: e.ctrl = 6'b000100;
          3'd5: e.ctrl = ins[30] ? 6'b001101 : 6'b000101;
          3'd6: e.ctrl = 6'b000110;
          default: e.ctrl = 6'b000111;
        endcase
      end
      7'h03: begin e.a = r1; e.b = ii; end
      7'h23: begin e.a = r1; e.b = is; end
      7'h63: begin
        if (ins[14:12] == 3'd2 || ins[14:12] == 3'd3) e.ill = 1'b1;
        else begin e.ctrl = {3'b010, ins[14:12]}; e.a = r1; e.b = r2; end
      end
      7'h6F, 7'h67: begin e.ctrl = 6'b011111; e.a = p + 32'd4; end
      7'h37: e.b = iu;
      7'h17: begin e.a = p; e.b = iu; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Offer one beat until accepted; push its expected result on acceptance
  task automatic drive(input logic [31:0] ins, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2,
                       output int waited);
    bit acc;
    acc = 0;
    waited = 0;
    instruction = ins; pc = p; rs1_data = r1; rs2_data = r2;
    in_valid = 1'b1;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clock);
      if (in_ready) begin
        sb.push_back(model(ins, p, r1, r2));
        acc = 1;
      end else begin
        waited++;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("drive_timeout", 64'd0, 64'd1);
  endtask

  // Scoreboard monitor: compare every output transfer
  always @(negedge clock) begin
    if (reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ctrl",    64'(ALU_Control), 64'(e.ctrl));
        chk("sb_opA",     64'(operand_A),   64'(e.a));
        chk("sb_opB",     64'(operand_B),   64'(e.b));
        chk("sb_rd",      64'(rd),          64'(e.rd));
        chk("sb_illegal", 64'(illegal),     64'(e.ill));
      end
    end
  end

  int w;
  int acc_cnt;
  exp_t first;

  initial begin
    // Reset state
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_ctrl",      64'(ALU_Control), 64'd0);
    chk("rst_opA",       64'(operand_A), 64'd0);
    chk("rst_opB",       64'(operand_B), 64'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b1;
    #1 chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    out_ready = 1'b1;

    // addi x5,x1,-3
    drive(32'hFFD08293, 32'h0, 32'd10, 32'd0, w);
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_ctrl",  64'(ALU_Control), 64'd0);
    chk("addi_opA",   64'(operand_A), 64'd10);
    chk("addi_opB",   64'(operand_B), 64'hFFFFFFFD);
    chk("addi_rd",    64'(rd), 64'd5);

    // sra then sub back to back
    drive(32'h4020D1B3, 32'h4, 32'h80000000, 32'd4, w);
    chk("sra_ctrl", 64'(ALU_Control), 64'b001101);
    drive(32'h402081B3, 32'h8, 32'd100, 32'd7, w);
    chk("sub_no_bubble_wait", 64'(w), 64'd0);
    chk("sub_valid", 64'(out_valid), 64'd1);
    chk("sub_ctrl", 64'(ALU_Control), 64'b001000);

    // jal at pc 0x100
    drive(32'h004000EF, 32'h100, 32'd1, 32'd2, w);
    chk("jal_ctrl", 64'(ALU_Control), 64'b011111);
    chk("jal_opA",  64'(operand_A), 64'h104);
    chk("jal_opB",  64'(operand_B), 64'h0);

    // bgeu, illegal opcode, illegal branch f3, other formats
    drive(32'h0020F063, 32'h10, 32'd3, 32'd9, w);
    chk("bgeu_ctrl", 64'(ALU_Control), 64'b010111);
    drive(32'h0000007F, 32'h14, 32'd3, 32'd9, w);
    chk("ill_flag", 64'(illegal), 64'd1);
    chk("ill_ctrl", 64'(ALU_Control), 64'd0);
    drive(32'h00002063, 32'h18, 32'd3, 32'd9, w);
    drive(32'hFE20AE23, 32'h1C, 32'h1000, 32'd5, w);
    drive(32'hFF80A183, 32'h20, 32'h2000, 32'd5, w);
    drive(32'h123451B7, 32'h24, 32'd1, 32'd1, w);
    drive(32'h12345197, 32'h28, 32'd1, 32'd1, w);
    drive(32'h000280E7, 32'hFFFFFFFC, 32'd1, 32'd1, w);
    drive(32'h4030D093, 32'h2C, 32'hF0000000, 32'd1, w);
    drive(32'h0040A113, 32'h30, 32'd3, 32'd1, w);
    @(posedge clock); #1;

    // Stall: 3 beats offered with out_ready low
    out_ready = 1'b0;
    acc_cnt = 0;
    first = model(32'h00100093, 32'h40, 32'd11, 32'd0);
    for (int k = 0; k < 3; k++) begin
      instruction = 32'h00100093 + (32'(acc_cnt) << 20);
      pc = 32'h40; rs1_data = 32'd11 + 32'(acc_cnt); rs2_data = 32'd0;
      in_valid = 1'b1;
      @(negedge clock);
      if (in_ready) begin
        sb.push_back(model(instruction, pc, rs1_data, rs2_data));
        acc_cnt++;
      end
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(negedge clock);
`ifdef ALU_ISSUE_SKID_EN
    chk("stall_accepted", 64'(acc_cnt), 64'd2);
`else
    chk("stall_accepted", 64'(acc_cnt), 64'd1);
`endif
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_hold_opA", 64'(operand_A), 64'(first.a));
    chk("stall_hold_opB", 64'(operand_B), 64'(first.b));
    @(posedge clock); #1;
    out_ready = 1'b1;
    for (int t = 0; t < 10 && sb.size() != 0; t++) @(posedge clock);
    #1 chk("drain_empty", 64'(sb.size()), 64'd0);

    // Flush with held beats plus an incoming beat
    out_ready = 1'b0;
    drive(32'h00500113, 32'h50, 32'd1, 32'd0, w);
    instruction = 32'h00600113; in_valid = 1'b1;
    @(negedge clock);
    if (in_ready) sb.push_back(model(instruction, pc, rs1_data, rs2_data));
    @(posedge clock); #1;
    instruction = 32'h00700113; flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (4) @(posedge clock);
    #1 chk("flush_stays_empty", 64'(out_valid), 64'd0);

    // Reset asserted mid-stall
    out_ready = 1'b0;
    drive(32'hFFD08293, 32'h60, 32'd77, 32'd0, w);
    @(negedge clock); #2;
    reset = 1'b0;
    #1;
    sb.delete();
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_ctrl", 64'(ALU_Control), 64'd0);
    chk("midrst_opA", 64'(operand_A), 64'd0);
    chk("midrst_opB", 64'(operand_B), 64'd0);
    chk("midrst_rd", 64'(rd), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    out_ready = 1'b1;
    #1 chk("rerst_in_ready", 64'(in_ready), 64'd1);
    drive(32'h0020F063, 32'h70, 32'd5, 32'd6, w);
    for (int t = 0; t < 10 && sb.size() != 0; t++) @(posedge clock);
    #1 chk("final_empty", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode/issue stage that drives the execute-stage ALU. It takes a raw RV32I instruction with its register-file operands and PC, and decodes it into the 6-bit `ALU_Control` code and the `operand_A`/`operand_B` pair. It registers the result toward the ALU behind a valid/ready handshake. It sits between register-file read and the ALU, and supports stall (backpressure) and flush (branch/jump redirect).

## Interface
- `DATA_WIDTH`, 32, width of operands, PC and immediates.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous; discards all held and incoming beats.
- `in_valid`  in  1  upstream beat present.
- `in_ready`  out  1  stage can accept a beat.
- `instruction`  in  32  RV32I instruction word.
- `pc`  in  DATA_WIDTH  address of `instruction`.
- `rs1_data`, `rs2_data`  in  DATA_WIDTH  register-file read data.
- `out_valid`  out  1  issued beat present.
- `out_ready`  in  1  execute stage accepts the beat.
- `ALU_Control`  out  6  ALU operation code.
- `operand_A`, `operand_B`  out  DATA_WIDTH  ALU operands.
- `rd`  out  5  `instruction[11:7]`, passed through.
- `illegal`  out  1  unsupported opcode or funct combination.

## Operation
- Transfer on the input side occurs when `in_valid & in_ready`. Transfer on the output side occurs when `out_valid & out_ready`.
- Decode by opcode `instruction[6:0]`, using f3 = `[14:12]` and f7b = `[30]`.
- OP (0110011), A=rs1, B=rs2:
  - f3 000: `000000` ADD, or `001000` SUB when f7b=1.
  - f3 001 `000001`, 010 `000010`, 011 `000011`, 100 `000100`, 110 `000110`, 111 `000111`.
  - f3 101: `000101` SRL, or `001101` SRA when f7b=1.
- OP-IMM (0010011): same codes, except ADDI is always `000000`. A=rs1, B=sign-extended `[31:20]`.
- LOAD (0000011): `000000`, A=rs1, B=I-immediate.
- STORE (0100011): `000000`, A=rs1, B=S-immediate `{[31:25],[11:7]}` sign-extended.
- BRANCH (1100011): `010`,f3 for f3 ∈ {000,001,100,101,110,111}. A=rs1, B=rs2. f3 010/011 is illegal.
- JAL (1101111) and JALR (1100111): `011111`, A=pc+4 (mod 2^DATA_WIDTH), B=0.
- LUI (0110111): `000000`, A=0, B=`{[31:12],12'b0}`.
- AUIPC (0010111): `000000`, A=pc, B=`{[31:12],12'b0}`.
- Any other opcode or illegal f3: `ALU_Control`=`000000`, A=B=0, `illegal`=1. The beat still issues.
- Output fields are held stable while `out_valid & !out_ready`.
- `flush`:
  - Next edge clears all held beats; `out_valid`=0.
  - An input beat presented in the same cycle is dropped.
  - `flush` overrides simultaneous transfers.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Reset (async assert, sync release):
  - `out_valid`=0, `ALU_Control`=0, `operand_A`=`operand_B`=0, `rd`=0, `illegal`=0.
  - `in_ready`=1 once reset is deasserted; it is 0 while `reset`=0.
- Reset mid-operation: held beats are lost, with no partial output.
- Simultaneous output and input transfer keeps the pipeline full with no bubble.

## Configuration
- `ALU_ISSUE_SKID_EN` defined:
  - Adds a 2-entry skid buffer (output register plus skid register).
  - `in_ready` is registered, = !skid_valid.
  - A beat accepted while the output is stalled parks in the skid register. It moves to the output register on the next output transfer.
  - There is no combinational path from `out_ready` to `in_ready`.
- Undefined:
  - Single output register.
  - `in_ready` = `!out_valid | out_ready`, which is combinational.
- Decode, latency and flush behaviour are identical in both builds.

## Test plan
- `addi x5,x1,-3` (0xFFD08293), rs1=10, in_valid=1, out_ready=1:
  - Next cycle: out_valid=1, ALU_Control=000000, A=10, B=0xFFFFFFFD, rd=5.
- `sra` (0x4020D1B3) then `sub` (0x402081B3) back to back:
  - Codes 001101 then 001000 on consecutive cycles, with no bubble.
- `jal` with pc=0x100 -> ALU_Control=011111, A=0x104, B=0.
- `bgeu` (f3=111) -> `010111`.
- Opcode 0x7F -> illegal=1, ALU_Control=0.
- Stall, with out_ready=0 for 3 cycles while 3 beats are offered:
  - Outputs hold the first beat.
  - With the skid buffer: 2 beats accepted, then in_ready=0.
  - Without: 1 beat accepted.
  - Release drains them in order.
- Flush with 2 beats held plus one incoming:
  - out_valid=0 next cycle; the incoming beat never appears.
  - Assert reset mid-stall -> all outputs 0 immediately.
